// File: rtl/nc_pkg.sv
// Shared types for the number cruncher: command opcodes and FSM states.
// No logic; imported by nc_alu and number_cruncher_seq.
// Contents: op_t (LOAD/ADD/SUB/SHOW), state_t (IDLE/FETCH/EXEC/WB), CMD_LATENCY.
package nc_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ADD  = 2'b01,
      OP_SUB  = 2'b10,
      OP_SHOW = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_EXEC  = 2'b10,
      S_WB    = 2'b11
   } state_t;

   // Clock edges from command acceptance to the done pulse.
   localparam int CMD_LATENCY = 3;

endpackage

// File: rtl/nc_alu.sv
// Purpose: WIDTH-bit add/subtract with carry/borrow flag, optional saturation.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: a, b operands; sub selects a-b (else a+b); res result; cout carry (add) or borrow (sub).
// Build option: NC_SATURATE_EN clamps to all-ones on carry and to zero on borrow.
module nc_alu #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] res,
   output logic             cout
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] raw;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      // Top bit of the extended difference is set exactly when a < b.
      diff = {1'b0, a} - {1'b0, b};
      cout = sub ? diff[WIDTH] : sum[WIDTH];
      raw  = sub ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
`ifdef NC_SATURATE_EN
      if (cout)
         res = sub ? '0 : '1;
      else
         res = raw;
`else
      res = raw;
`endif
   end

endmodule

// File: rtl/number_cruncher_seq.sv
// Purpose: NREGS x WIDTH register file with LOAD/ADD/SUB/SHOW sequenced by a 4-state FSM.
// Latency: done pulses 3 cycles after accept; a new command can be accepted every 4 cycles.
// Backpressure: cmd_ready high only in IDLE; cmd_valid while busy is dropped, not queued.
// Ports: clk, rst (async, active high); cmd_valid/cmd_ready handshake with cmd_op, cmd_dst,
//        cmd_srca, cmd_srcb, cmd_imm; out_q display register; cout last carry/borrow; done pulse.
// Build option: NC_SATURATE_EN (passed through to nc_alu) selects saturating arithmetic.
module number_cruncher_seq
   import nc_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int NREGS = 4,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [AW-1:0]    cmd_dst,
   input  logic [AW-1:0]    cmd_srca,
   input  logic [AW-1:0]    cmd_srcb,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic [WIDTH-1:0] out_q,
   output logic             cout,
   output logic             done
);

   state_t           state;
   logic [WIDTH-1:0] regs [NREGS];

   // Command latch: cmd_* are free to change once accepted.
   op_t              c_op;
   logic [AW-1:0]    c_dst;
   logic [AW-1:0]    c_srca;
   logic [AW-1:0]    c_srcb;
   logic [WIDTH-1:0] c_imm;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res_q;
   logic             res_cout;

   logic [WIDTH-1:0] alu_res;
   logic             alu_cout;

   nc_alu #(.WIDTH(WIDTH)) u_alu (
      .a    (op_a),
      .b    (op_b),
      .sub  (c_op == OP_SUB),
      .res  (alu_res),
      .cout (alu_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b1;
         done      <= 1'b0;
         out_q     <= '0;
         cout      <= 1'b0;
         c_op      <= OP_LOAD;
         c_dst     <= '0;
         c_srca    <= '0;
         c_srcb    <= '0;
         c_imm     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         res_q     <= '0;
         res_cout  <= 1'b0;
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  c_op      <= op_t'(cmd_op);
                  c_dst     <= cmd_dst;
                  c_srca    <= cmd_srca;
                  c_srcb    <= cmd_srcb;
                  c_imm     <= cmd_imm;
                  cmd_ready <= 1'b0;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: begin
               // Operands sampled here, so a dst that aliases a source sees the old value.
               op_a  <= regs[c_srca];
               op_b  <= regs[c_srcb];
               state <= S_EXEC;
            end
            S_EXEC: begin
               case (c_op)
                  OP_LOAD: res_q <= c_imm;
                  OP_SHOW: res_q <= op_a;
                  default: res_q <= alu_res;
               endcase
               res_cout <= alu_cout;
               state    <= S_WB;
            end
            S_WB: begin
               case (c_op)
                  OP_LOAD: regs[c_dst] <= res_q;
                  OP_SHOW: out_q       <= res_q;
                  default: begin
                     regs[c_dst] <= res_q;
                     cout        <= res_cout;
                  end
               endcase
               done      <= 1'b1;
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: begin
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
